// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation path: controller state encoding,
// default rate/stage limits and the rate clamp helper.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } ctrl_state_t;

  localparam int MAX_RATE_LOG2_DEF = 6;
  localparam int N_STAGES_DEF      = 3;

  function automatic int clamp_rate(input int req, input int max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/cic_dec_ctrl_phase_cnt.sv
// Sample phase counter: counts enabled samples and flags the sample that
// reaches the terminal count, wrapping back to zero on that sample.
module cic_phase_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = en && (cnt == term);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// CIC decimation sequencing controller: issues the decimate tick every 2^rate
// samples, discards the comb priming ticks, and hands samples downstream.
module cic_dec_ctrl
  import cic_pkg::*;
#(
  parameter  int MAX_RATE_LOG2 = MAX_RATE_LOG2_DEF,
  parameter  int N_STAGES      = N_STAGES_DEF,
  localparam int RL_W          = $clog2(MAX_RATE_LOG2 + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            cfg_load,
  input  logic [RL_W-1:0] rate_log2,
  input  logic            in_valid,
  output logic            integ_en,
  output logic            dec_tick,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun,
  output logic            settling,
  output logic [RL_W-1:0] rate_cur
);

  localparam int SC_W = $clog2(N_STAGES + 1);

  ctrl_state_t              state, state_nxt;
  logic        [SC_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic                     dec_tick_nxt, out_valid_nxt, overrun_nxt;
  logic                     active, latch_rate, restart, cnt_clr, cnt_en, wrap;
  logic                     settle_done;
  logic [MAX_RATE_LOG2-1:0] term;

  assign active      = (state != IDLE);
  assign latch_rate  = en && ((state == IDLE) || cfg_load);
  assign restart     = !en || cfg_load || (state == IDLE);
  assign cnt_clr     = restart;
  assign cnt_en      = in_valid && active;
  assign integ_en    = in_valid && active;
  assign settling    = (state == SETTLE);
  assign settle_done = (state == SETTLE) && dec_tick && (settle_cnt == SC_W'(N_STAGES - 1));

  // Terminal phase is 2^rate_cur - 1: the low rate_cur bits set.
  always_comb begin
    term = '0;
    for (int i = 0; i < MAX_RATE_LOG2; i++) begin
      term[i] = (i < int'(rate_cur));
    end
  end

  cic_phase_cnt #(
    .CNT_W (MAX_RATE_LOG2)
  ) u_phase (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (term),
    .wrap (wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dec_tick   <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      rate_cur   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      dec_tick   <= dec_tick_nxt;
      out_valid  <= out_valid_nxt;
      overrun    <= overrun_nxt;
      if (latch_rate) begin
        rate_cur <= RL_W'(clamp_rate(int'(rate_log2), MAX_RATE_LOG2));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SETTLE;
        SETTLE:  if (!cfg_load && settle_done) state_nxt = RUN;
        RUN:     if (cfg_load) state_nxt = SETTLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A restart discards any wrap seen in the same cycle, so cfg_load beats the tick.
  always_comb begin
    dec_tick_nxt   = wrap && en && !cfg_load;
    out_valid_nxt  = out_valid;
    overrun_nxt    = overrun;
    settle_cnt_nxt = settle_cnt;
    if (restart) begin
      out_valid_nxt  = 1'b0;
      overrun_nxt    = 1'b0;
      settle_cnt_nxt = '0;
    end else if (state == SETTLE) begin
      if (dec_tick) settle_cnt_nxt = settle_cnt + SC_W'(1);
    end else if (state == RUN) begin
      if (dec_tick) begin
        out_valid_nxt = 1'b1;
        if (out_valid && !out_ready) overrun_nxt = 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: reset, rate sequencing, settling,
// handshake/overrun, rate change, clamp, R=1 and abort scenarios.
module tb_cic_dec_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       cfg_load = 1'b0;
  logic [2:0] rate_log2 = 3'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       integ_en, dec_tick, out_valid, overrun, settling;
  logic [2:0] rate_cur;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cic_dec_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_load  (cfg_load),
    .rate_log2 (rate_log2),
    .in_valid  (in_valid),
    .integ_en  (integ_en),
    .dec_tick  (dec_tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .settling  (settling),
    .rate_cur  (rate_cur)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step n cycles: dec_tick must stay low for the first n-1 and be high on the n-th.
  task automatic tick_in(input int n, input string tag);
    int early;
    early = 0;
    for (int i = 1; i < n; i++) begin
      step();
      if (dec_tick !== 1'b0) early++;
    end
    step();
    chk({tag, "_quiet"}, early, 0);
    chk({tag, "_tick"}, dec_tick, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nz;
    logic pat [8];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with en high and in_valid toggling
    en = 1'b1; rate_log2 = 3'd2;
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      step();
      if (dec_tick || out_valid || overrun || settling || integ_en || (rate_cur != 3'd0)) nz++;
    end
    chk("rst_outputs_zero", nz, 0);

    // Released with en low: stays idle
    rstn = 1'b1; en = 1'b0; in_valid = 1'b1;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dec_tick || settling || integ_en || out_valid) nz++;
    end
    chk("idle_no_activity", nz, 0);

    // Basic R=4
    en = 1'b1; rate_log2 = 3'd2; out_ready = 1'b0;
    tick_in(5, "b_t1");
    chk("b_t1_settling", settling, 1);
    chk("b_t1_out_valid", out_valid, 0);
    chk("b_rate_cur", rate_cur, 2);
    tick_in(4, "b_t2");
    chk("b_t2_settling", settling, 1);
    tick_in(4, "b_t3");
    chk("b_t3_settling", settling, 1);
    chk("b_t3_out_valid", out_valid, 0);
    tick_in(4, "b_t4");
    chk("b_t4_run", settling, 0);
    chk("b_t4_out_valid", out_valid, 0);
    chk("b_integ_en", integ_en, 1);
    step();
    chk("b_out_valid_set", out_valid, 1);
    chk("b_no_overrun", overrun, 0);

    // Handshake and overrun
    tick_in(3, "h_t5");
    step();
    chk("h_overrun_set", overrun, 1);
    chk("h_out_valid_hold", out_valid, 1);
    tick_in(3, "h_t6");
    out_ready = 1'b1;
    step();
    chk("h_ready_on_tick_valid", out_valid, 1);
    chk("h_overrun_sticky", overrun, 1);
    step();
    chk("h_accept_clears", out_valid, 0);
    out_ready = 1'b0;
    tick_in(2, "h_t7");
    step();
    chk("h_out_valid_again", out_valid, 1);

    // Rate change to R=16
    rate_log2 = 3'd4; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("r_out_valid_drop", out_valid, 0);
    chk("r_overrun_clear", overrun, 0);
    chk("r_settling", settling, 1);
    chk("r_rate_cur", rate_cur, 4);
    tick_in(16, "r_t1");
    rate_log2 = 3'd1;
    tick_in(16, "r_t2");
    chk("r_ignore_no_load", rate_cur, 4);
    tick_in(16, "r_t3");
    chk("r_t3_settling", settling, 1);
    chk("r_t3_out_valid", out_valid, 0);
    tick_in(16, "r_t4");
    chk("r_t4_run", settling, 0);
    step();
    chk("r_out_valid_set", out_valid, 1);

    // Clamp 7 -> 6 (R=64)
    rate_log2 = 3'd7; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("c_clamp", rate_cur, 6);
    chk("c_settling", settling, 1);
    tick_in(64, "c_t1");
    tick_in(64, "c_t2");

    // R=1 with gapped input
    rate_log2 = 3'd0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("u_rate_cur", rate_cur, 0);
    chk("u_no_tick_on_load", dec_tick, 0);
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    chk("u_t1", dec_tick, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i];
      step();
      chk($sformatf("u_gap%0d", i), dec_tick, pat[i]);
    end
    chk("u_out_valid", out_valid, 1);
    chk("u_run", settling, 0);
    chk("u_overrun0", overrun, 0);
    in_valid = 1'b1;
    step();
    chk("u_accept", out_valid, 0);
    step();
    step();
    chk("u_ready_tick_keep", out_valid, 1);
    chk("u_ready_tick_no_overrun", overrun, 0);

    // cfg_load coincident with a wrap suppresses the tick
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("w_cfg_wins_tick", dec_tick, 0);
    chk("w_cfg_wins_settling", settling, 1);
    chk("w_cfg_wins_out_valid", out_valid, 0);

    // Build overrun at R=1, then abort with en=0
    out_ready = 1'b0;
    repeat (8) step();
    chk("a_pre_out_valid", out_valid, 1);
    chk("a_pre_overrun", overrun, 1);
    en = 1'b0;
    step();
    chk("a_out_valid_clear", out_valid, 0);
    chk("a_overrun_clear", overrun, 0);
    chk("a_idle", settling, 0);
    chk("a_no_tick", dec_tick, 0);
    chk("a_integ_en_off", integ_en, 0);

    // Abort at phase 2 must clear the phase counter
    rate_log2 = 3'd2; en = 1'b1;
    step();
    chk("a_rate_latch_idle", rate_cur, 2);
    step();
    step();
    en = 1'b0;
    step();
    chk("a_phase_idle", settling, 0);
    en = 1'b1;
    step();
    tick_in(4, "a_phase_cleared");

    // Asynchronous reset while in RUN
    rate_log2 = 3'd0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    repeat (6) step();
    chk("x_pre_run", settling, 0);
    chk("x_pre_out_valid", out_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("x_out_valid", out_valid, 0);
    chk("x_overrun", overrun, 0);
    chk("x_settling", settling, 0);
    chk("x_rate_cur", rate_cur, 0);
    chk("x_dec_tick", dec_tick, 0);
    chk("x_integ_en", integ_en, 0);
    step();
    step();
    rstn = 1'b1; en = 1'b0;
    step();
    chk("x_post_idle", settling, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Sequencing controller for the CIC decimation path.
- Counts accepted input samples and issues the 1-cycle decimate tick that loads the decimator register and enables the comb stages.
- Suppresses output after start or rate change until the combs have primed, then presents decimated samples through a valid/ready handshake with overrun detection.
- Replaces the external slow clock with a single-clock enable scheme.

Parameters:
- MAX_RATE_LOG2, 6, log2 of the largest supported decimation rate (max R = 64).
- N_STAGES, 3, number of comb stages; also the number of ticks discarded while settling.
- RL_W, $clog2(MAX_RATE_LOG2+1), width of the rate-select field (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  filter enable; low forces IDLE.
- cfg_load  in  1  1-cycle pulse; latch rate_log2 and restart settling.
- rate_log2  in  RL_W  requested decimation rate as log2 (R = 2^rate_log2).
- in_valid  in  1  input sample strobe from the integrator side.
- integ_en  out  1  integrator clock-enable.
- dec_tick  out  1  1-cycle decimate strobe to decimator and comb stages.
- out_valid  out  1  decimated sample available.
- out_ready  in  1  downstream accepts sample.
- overrun  out  1  sticky: a sample was lost.
- settling  out  1  high in SETTLE state.
- rate_cur  out  RL_W  rate currently in effect.

Behaviour:
- Reset values (asynchronous):
  - State IDLE; phase counter 0; settle counter 0.
  - dec_tick=0, out_valid=0, overrun=0, settling=0, rate_cur=0.
- integ_en = in_valid && state != IDLE (combinational).
- Rate latch: on the first en-high cycle in IDLE, or on cfg_load while en=1, latch rate_cur = min(rate_log2, MAX_RATE_LOG2).
- States:
  - IDLE: no ticks.
  - IDLE -> SETTLE when en=1 (same cycle as the rate latch).
  - SETTLE -> RUN after N_STAGES dec_ticks have been issued in SETTLE.
  - Any state -> IDLE on the cycle after en=0. Counters clear, out_valid clears, overrun clears.
  - cfg_load with en=1 in SETTLE or RUN -> SETTLE. Phase and settle counters clear, out_valid clears, overrun clears.
- Phase counter (width MAX_RATE_LOG2):
  - Increments on each in_valid in SETTLE or RUN.
  - When in_valid and phase == 2^rate_cur - 1: phase wraps to 0 and dec_tick is registered high for the next cycle only.
  - rate_cur = 0 gives R = 1: a tick follows every in_valid.
  - Latency: dec_tick is asserted exactly 1 cycle after the R-th sample's in_valid.
- dec_tick fires in SETTLE too, so the combs prime; out_valid is never set in SETTLE.
- Output handshake (RUN only):
  - dec_tick sets out_valid.
  - out_valid && out_ready clears out_valid unless a dec_tick arrives in the same cycle. In that case out_valid stays 1 and overrun is not set.
  - dec_tick while out_valid=1 and out_ready=0 sets overrun (sticky). out_valid stays 1; the sample is replaced downstream.
- Simultaneous events:
  - cfg_load and a phase wrap in the same cycle: cfg_load wins; no tick is issued.
  - en=0 overrides cfg_load.
- rate_log2 changes without cfg_load are ignored.
- Asynchronous reset mid-operation returns immediately to the reset values above.

Decomposition:
- Package cic_pkg:
  - State enum ctrl_state_t {IDLE, SETTLE, RUN}.
  - MAX_RATE_LOG2 and N_STAGES default localparams, shared with the integrator, comb and decimator blocks.
  - Function clamp_rate().
- One sub-module, cic_phase_cnt:
  - Phase counter with sync clear, enable and terminal-count tick output.
  - Instantiated once; the FSM and handshake live in the top.

Test Plan:
- Reset/idle: rstn low with en=1 and in_valid toggling -> all outputs 0. After release with en=0 -> no dec_tick for 100 cycles.
- Basic rate: rate_log2=2, en=1, in_valid every cycle -> dec_tick every 4th cycle, 1 cycle after the 4th sample.
  - First 3 ticks have settling=1 and out_valid=0; the 4th tick raises out_valid.
- Handshake/overrun:
  - RUN with R=4, out_ready=0 -> second tick sets overrun=1 and out_valid stays 1.
  - out_ready=1 on a tick cycle -> out_valid stays 1, overrun unchanged.
- Rate change: in RUN, rate_log2=4 with cfg_load pulse -> out_valid drops next cycle, settling=1, rate_cur=4.
  - Ticks then every 16 samples; 3 settle ticks before out_valid returns.
- Clamp and R=1:
  - rate_log2=7 with cfg_load -> rate_cur=6, tick every 64 samples.
  - rate_log2=0 -> tick after every in_valid, including gapped in_valid patterns.
- Mid-operation abort:
  - en=0 with phase=2 -> IDLE next cycle, counters 0, out_valid/overrun cleared.
  - Async rstn pulse in RUN -> immediate reset values.
